alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port ctrl, input, 3 bits: opcode, with 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL, and 101-111 illegal.
REQ-009 SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 SHALL have ports zero, overflow, carry, and illegal, each an output of 1 bit, carrying the status flags.

Function
REQ-013 SHALL implement a state machine with three states, IDLE, MUL, and DONE, where in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge in IDLE when in_valid=1, capturing a, b, and ctrl; later changes on the inputs are ignored until the next accept.
REQ-015 SHALL, for an accepted ADD/SUB/XOR/SLT/illegal opcode, compute the result and flags and move to DONE, so that out_valid=1 exactly one cycle after the accept edge.
REQ-016 SHALL, for an accepted MUL, move to MUL and run an unsigned shift-add over exactly WIDTH cycles, then move to DONE, so that out_valid=1 exactly WIDTH+1 cycles after the accept edge.
REQ-017 SHALL, in DONE, hold out_valid, result, and all flags stable until out_ready=1, then return to IDLE on that edge; out_valid and in_ready are never 1 in the same cycle.
REQ-018 SHALL compute ADD as result = a+b mod 2^WIDTH, with carry = carry out of the MSB and overflow = signed overflow (carry into MSB xor carry out of MSB).
REQ-019 SHALL compute SUB as result = a + ~b + 1 mod 2^WIDTH, with carry = 1 when a >= b unsigned (no borrow) and overflow = signed overflow.
REQ-020 SHALL compute XOR as result = a ^ b, with overflow=0 and carry=0.
REQ-021 SHALL compute SLT as result = 1 when a < b signed and 0 otherwise, derived as sign(a-b) xor overflow(a-b) with upper bits zero; overflow=0 and carry=0.
REQ-022 SHALL compute MUL as result = low WIDTH bits of the unsigned product a*b, with overflow = 1 when any high WIDTH bits of the product are nonzero, and carry=0.
REQ-023 SHALL, for an illegal opcode, set result=0 and illegal=1; for a legal opcode, illegal=0.
REQ-024 SHALL set zero=1 exactly when the final registered result equals 0, for every opcode including SLT and illegal.
REQ-025 SHALL handle MUL operands of 0 or 1 and all-ones (2^WIDTH-1) correctly, with no early termination; latency is fixed at WIDTH+1 regardless of operand values.
REQ-026 SHALL ignore out_ready outside DONE and ignore in_valid outside IDLE.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, out_valid=0, result=0, zero=0, overflow=0, carry=0, illegal=0, and in_ready=0.
REQ-028 SHALL assert in_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-029 SHALL, on rst_n asserted mid-MUL or in DONE, abandon the operation immediately; no out_valid is produced for it after reset.

Verification
REQ-030 SHALL be verified with WIDTH=32, ADD, a=0x7FFFFFFF, b=1 -> after one cycle result=0x80000000, overflow=1, carry=0, zero=0.
REQ-031 SHALL be verified with WIDTH=32, SUB, a=5, b=5 -> result=0, zero=1, carry=1, overflow=0; then SUB, a=2, b=5 -> result=0xFFFFFFFD, carry=0.
REQ-032 SHALL be verified with WIDTH=32, SLT, a=0x80000000, b=1 -> result=1; and SLT, a=1, b=0x80000000 -> result=0, zero=1.
REQ-033 SHALL be verified with WIDTH=32, MUL, a=0x10000, b=0x10000 -> out_valid exactly 33 cycles after accept, result=0, overflow=1, zero=1; and MUL, a=6, b=7 -> result=42, overflow=0.
REQ-034 SHALL be verified with out_ready held 0 for 5 cycles in DONE -> result and flags stable and in_ready=0 throughout; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-035 SHALL be verified with rst_n pulsed low 10 cycles into a MUL -> outputs zero immediately, no out_valid follows, and a fresh ADD 3+4 then returns 7; ctrl=110 returns result=0, illegal=1, zero=1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/XOR/SLT, WIDTH-cycle shift-add MUL.
// valid/ready: a transfer happens on a rising edge where both valid and ready are 1.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               started;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     upper;
    logic               accept, is_mul, mul_last;

    logic [WIDTH:0]     sum, diff;
    logic               add_ovf, sub_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_ill;

    // in_ready stays low until the first edge after reset releases
    assign in_ready  = (state == IDLE) && started;
    assign out_valid = (state == DONE);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (ctrl == 3'b100);
    assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_mul ? MUL : DONE;
            MUL:     if (mul_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (ctrl)
            3'b000: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  alu_v = add_ovf; end
            3'b001: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; alu_v = sub_ovf; end
            3'b010: alu_res = a ^ b;
            3'b011: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            3'b100: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Low half of prod holds the remaining multiplier bits; high half accumulates.
    always_comb begin
        upper    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        prod_nxt = {upper, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                if (is_mul) begin
                    mcand <= a;
                    prod  <= {{WIDTH{1'b0}}, b};
                    cnt   <= '0;
                end else begin
                    result   <= alu_res;
                    zero     <= (alu_res == '0);
                    overflow <= alu_v;
                    carry    <= alu_c;
                    illegal  <= alu_ill;
                end
            end else if (state == MUL) begin
                prod <= prod_nxt;
                cnt  <= cnt + CW'(1);
                if (mul_last) begin
                    result   <= prod_nxt[WIDTH-1:0];
                    zero     <= (prod_nxt[WIDTH-1:0] == '0);
                    overflow <= |prod_nxt[2*WIDTH-1:WIDTH];
                    carry    <= 1'b0;
                    illegal  <= 1'b0;
                end
            end
        end
    end

endmodule
